// File: rtl/clock_pkg.sv
// Shared types and constants for the clock/stopwatch/timer mode controller.
`timescale 1ns/1ps
package clock_pkg;

    typedef enum logic [1:0] {
        CLOCK     = 2'd0,
        STOPWATCH = 2'd1,
        TIMER     = 2'd2,
        SET       = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } tmr_state_t;

    localparam logic [1:0] FIELD_SEC = 2'd0;
    localparam logic [1:0] FIELD_MIN = 2'd1;
    localparam logic [1:0] FIELD_HR  = 2'd2;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            CLOCK:     return STOPWATCH;
            STOPWATCH: return TIMER;
            TIMER:     return SET;
            default:   return CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_field_inc.sv
// Next value with wrap for the field being edited, plus its one-hot load mask.
`timescale 1ns/1ps
module field_inc
    import clock_pkg::*;
#(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59,
    parameter int HR_MAX  = 23
) (
    input  logic [1:0]       field_sel,
    input  logic [SEC_W-1:0] sec_val,
    input  logic [MIN_W-1:0] min_val,
    input  logic [HR_W-1:0]  hr_val,
    output logic [2:0]       load_mask,
    output logic [7:0]       next_val
);

    localparam logic [SEC_W-1:0] SEC_TERM = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_TERM = MIN_W'(MIN_MAX);
    localparam logic [HR_W-1:0]  HR_TERM  = HR_W'(HR_MAX);

    // An unused field_sel encoding falls back to the seconds field.
    always_comb begin
        load_mask = 3'b001;
        next_val  = 8'd0;
        case (field_sel)
            FIELD_MIN: begin
                load_mask = 3'b010;
                next_val  = (min_val == MIN_TERM) ? 8'd0 : ({2'b00, min_val} + 8'd1);
            end
            FIELD_HR: begin
                load_mask = 3'b100;
                next_val  = (hr_val == HR_TERM) ? 8'd0 : ({3'b000, hr_val} + 8'd1);
            end
            default: begin
                load_mask = 3'b001;
                next_val  = (sec_val == SEC_TERM) ? 8'd0 : ({2'b00, sec_val} + 8'd1);
            end
        endcase
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode and sequencing controller driving the shared seconds/minutes/hours
// counter bank as a clock, stopwatch, countdown timer or setting interface.
`timescale 1ns/1ps
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MAX     = 59,
    parameter int MIN_MAX     = 59,
    parameter int HR_MAX      = 23,
    parameter int ALARM_TICKS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_mode,
    input  logic             btn_sel,
    input  logic             btn_inc,
    input  logic             btn_start,
    input  logic [SEC_W-1:0] sec_val,
    input  logic [MIN_W-1:0] min_val,
    input  logic [HR_W-1:0]  hr_val,
    input  logic             sec_imp,
    input  logic             min_imp,
    output logic [1:0]       rezhim,
    output logic             sec_en,
    output logic             min_en,
    output logic             hr_en,
    output logic             up_down,
    output logic [2:0]       setup_imp,
    output logic [7:0]       setup_data,
    output logic             timer_reset,
    output logic [1:0]       field_sel,
    output logic             alarm
);

    localparam int ACNT_W = $clog2(ALARM_TICKS + 1);

    mode_t              mode;
    mode_t              mode_nxt;
    tmr_state_t         tmr_state;
    logic               run;
    logic [ACNT_W-1:0]  alarm_cnt;
    logic [1:0]         rst_pipe;
    logic               rst_int;
    logic               bank_zero;
    logic               counting;
    logic               editing;
    logic               tmr_done;
    logic [1:0]         field_nxt;
    logic [2:0]         inc_mask;
    logic [7:0]         inc_val;

    // Reset asserts immediately but releases two clock edges later, aligned to the clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end
    assign rst_int = rst_pipe[1];

    assign rezhim    = mode;
    assign mode_nxt  = next_mode(mode);
    assign bank_zero = (sec_val == '0) && (min_val == '0) && (hr_val == '0);
    assign counting  = (mode == CLOCK) || ((mode == STOPWATCH) && run) ||
                       ((mode == TIMER) && (tmr_state == T_RUN));
    assign editing   = (mode == SET) || ((mode == TIMER) && (tmr_state == T_IDLE));
    assign tmr_done  = (mode == TIMER) && (tmr_state == T_DONE);
    assign field_nxt = (field_sel == FIELD_HR) ? FIELD_SEC : (field_sel + 2'd1);

    field_inc #(
        .SEC_MAX (SEC_MAX),
        .MIN_MAX (MIN_MAX),
        .HR_MAX  (HR_MAX)
    ) u_field_inc (
        .field_sel (field_sel),
        .sec_val   (sec_val),
        .min_val   (min_val),
        .hr_val    (hr_val),
        .load_mask (inc_mask),
        .next_val  (inc_val)
    );

    // Tick and carry effects use the pre-button state; button effects are
    // assigned afterwards so they take precedence over tick-driven state changes.
    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            mode        <= CLOCK;
            tmr_state   <= T_IDLE;
            run         <= 1'b0;
            field_sel   <= FIELD_SEC;
            alarm       <= 1'b0;
            alarm_cnt   <= '0;
            sec_en      <= 1'b0;
            min_en      <= 1'b0;
            hr_en       <= 1'b0;
            up_down     <= 1'b1;
            setup_imp   <= 3'b000;
            setup_data  <= 8'd0;
            timer_reset <= 1'b0;
        end else begin
            sec_en      <= 1'b0;
            min_en      <= 1'b0;
            hr_en       <= 1'b0;
            setup_imp   <= 3'b000;
            setup_data  <= 8'd0;
            timer_reset <= 1'b0;

            if (counting) begin
                min_en <= sec_imp;
                hr_en  <= min_imp;
                sec_en <= tick && !btn_mode && !((mode == TIMER) && bank_zero);
            end

            if (tick && !btn_mode && (mode == TIMER)) begin
                if ((tmr_state == T_RUN) && bank_zero) begin
                    tmr_state <= T_DONE;
                    alarm     <= 1'b1;
                    alarm_cnt <= ACNT_W'(ALARM_TICKS);
                end else if (tmr_state == T_DONE) begin
                    if (alarm_cnt <= ACNT_W'(1)) begin
                        alarm_cnt <= '0;
                        alarm     <= 1'b0;
                        tmr_state <= T_IDLE;
                    end else begin
                        alarm_cnt <= alarm_cnt - ACNT_W'(1);
                    end
                end
            end

            if (btn_mode) begin
                mode      <= mode_nxt;
                alarm     <= 1'b0;
                tmr_state <= T_IDLE;
                run       <= 1'b0;
                up_down   <= (mode_nxt != TIMER);
                if ((mode_nxt == STOPWATCH) || (mode_nxt == TIMER)) begin
                    timer_reset <= 1'b1;
                end
                if (mode_nxt == SET) begin
                    field_sel <= FIELD_SEC;
                end
            end else if (btn_start) begin
                if (mode == STOPWATCH) begin
                    run <= !run;
                end else if (mode == TIMER) begin
                    if (tmr_state == T_IDLE) begin
                        if (!bank_zero) begin
                            tmr_state <= T_RUN;
                        end
                    end else begin
                        tmr_state <= T_IDLE;
                        alarm     <= 1'b0;
                    end
                end
            end else if (btn_sel) begin
                if (editing) begin
                    field_sel <= field_nxt;
                end else if (tmr_done) begin
                    tmr_state <= T_IDLE;
                    alarm     <= 1'b0;
                end
            end else if (btn_inc) begin
                if ((mode == STOPWATCH) && !run) begin
                    timer_reset <= 1'b1;
                end else if (editing) begin
                    setup_imp  <= inc_mask;
                    setup_data <= inc_val;
                end else if (tmr_done) begin
                    tmr_state <= T_IDLE;
                    alarm     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl with a behavioural counter bank model.
`timescale 1ns/1ps
module tb_clock_mode_ctrl;
    import clock_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick, btn_mode, btn_sel, btn_inc, btn_start;
    logic [5:0] bank_sec, bank_min;
    logic [4:0] bank_hr;
    logic       sec_imp, min_imp;
    logic [1:0] rezhim;
    logic       sec_en, min_en, hr_en, up_down, timer_reset, alarm;
    logic [2:0] setup_imp;
    logic [7:0] setup_data;
    logic [1:0] field_sel;

    logic       preset_req;
    logic [5:0] preset_sec, preset_min;
    logic [4:0] preset_hr;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [2:0] en;
        logic [2:0] setup;
        logic [7:0] data;
        logic       tr;
        logic       ud;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t mon_act;
    strobe_t mon_exp;

    localparam logic [4:0] B_MODE  = 5'b10000;
    localparam logic [4:0] B_START = 5'b01000;
    localparam logic [4:0] B_SEL   = 5'b00100;
    localparam logic [4:0] B_INC   = 5'b00010;
    localparam logic [4:0] B_TICK  = 5'b00001;

    always #5 clock = ~clock;

    clock_mode_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .btn_mode    (btn_mode),
        .btn_sel     (btn_sel),
        .btn_inc     (btn_inc),
        .btn_start   (btn_start),
        .sec_val     (bank_sec),
        .min_val     (bank_min),
        .hr_val      (bank_hr),
        .sec_imp     (sec_imp),
        .min_imp     (min_imp),
        .rezhim      (rezhim),
        .sec_en      (sec_en),
        .min_en      (min_en),
        .hr_en       (hr_en),
        .up_down     (up_down),
        .setup_imp   (setup_imp),
        .setup_data  (setup_data),
        .timer_reset (timer_reset),
        .field_sel   (field_sel),
        .alarm       (alarm)
    );

    // Counter bank: wraps at 59/59/23 counting up, at 0 counting down; carry is combinational.
    assign sec_imp = sec_en && (up_down ? (bank_sec == 6'd59) : (bank_sec == 6'd0));
    assign min_imp = min_en && (up_down ? (bank_min == 6'd59) : (bank_min == 6'd0));

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_sec <= '0;
            bank_min <= '0;
            bank_hr  <= '0;
        end else if (preset_req) begin
            bank_sec <= preset_sec;
            bank_min <= preset_min;
            bank_hr  <= preset_hr;
        end else if (timer_reset) begin
            bank_sec <= '0;
            bank_min <= '0;
            bank_hr  <= '0;
        end else begin
            if (setup_imp[0])
                bank_sec <= setup_data[5:0];
            else if (sec_en)
                bank_sec <= up_down ? ((bank_sec == 6'd59) ? 6'd0 : bank_sec + 6'd1)
                                    : ((bank_sec == 6'd0) ? 6'd59 : bank_sec - 6'd1);
            if (setup_imp[1])
                bank_min <= setup_data[5:0];
            else if (min_en)
                bank_min <= up_down ? ((bank_min == 6'd59) ? 6'd0 : bank_min + 6'd1)
                                    : ((bank_min == 6'd0) ? 6'd59 : bank_min - 6'd1);
            if (setup_imp[2])
                bank_hr <= setup_data[4:0];
            else if (hr_en)
                bank_hr <= up_down ? ((bank_hr == 5'd23) ? 5'd0 : bank_hr + 5'd1)
                                   : ((bank_hr == 5'd0) ? 5'd23 : bank_hr - 5'd1);
        end
    end

    // Monitor: every cycle carrying any strobe must match the next expected record.
    always @(negedge clock) begin
        if (!reset && (sec_en || min_en || hr_en || timer_reset || (setup_imp != 3'b000))) begin
            mon_act = '{en: {hr_en, min_en, sec_en}, setup: setup_imp, data: setup_data,
                        tr: timer_reset, ud: up_down};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL strobe_unexpected: got %h, expected no strobe", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL strobe_record: got %h, expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectStrobe(input logic [2:0] en, input logic [2:0] setup,
                                input logic [7:0] data, input logic tr, input logic ud);
        exp_q.push_back('{en: en, setup: setup, data: data, tr: tr, ud: ud});
    endtask

    task automatic applyStimulus(input logic [4:0] v);
        {btn_mode, btn_start, btn_sel, btn_inc, tick} = v;
        @(posedge clock);
        #1;
        {btn_mode, btn_start, btn_sel, btn_inc, tick} = 5'b00000;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic presetBank(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        preset_hr  = h;
        preset_min = m;
        preset_sec = s;
        preset_req = 1'b1;
        @(posedge clock);
        #1;
        preset_req = 1'b0;
    endtask

    initial begin
        {btn_mode, btn_start, btn_sel, btn_inc, tick} = 5'b00000;
        preset_req = 1'b0;
        preset_sec = '0;
        preset_min = '0;
        preset_hr  = '0;
        reset      = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_rezhim", 32'(rezhim), 32'd0);
        checkOutput("reset_alarm", 32'(alarm), 32'd0);
        checkOutput("reset_up_down", 32'(up_down), 32'd1);
        checkOutput("reset_field_sel", 32'(field_sel), 32'd0);
        checkOutput("reset_strobes", 32'({sec_en, min_en, hr_en, timer_reset, setup_imp}), 32'd0);
        checkOutput("reset_setup_data", 32'(setup_data), 32'd0);
        reset = 1'b0;
        idle(4);

        // CLOCK: 00:59:59 rolls to 01:00:00 through the carry chain
        presetBank(5'd0, 6'd59, 6'd59);
        expectStrobe(3'b001, 3'b000, 8'd0, 1'b0, 1'b1);
        expectStrobe(3'b010, 3'b000, 8'd0, 1'b0, 1'b1);
        expectStrobe(3'b100, 3'b000, 8'd0, 1'b0, 1'b1);
        applyStimulus(B_TICK);
        idle(4);
        checkOutput("clock_roll_hr", 32'(bank_hr), 32'd1);
        checkOutput("clock_roll_min", 32'(bank_min), 32'd0);
        checkOutput("clock_roll_sec", 32'(bank_sec), 32'd0);

        // CLOCK ignores edit buttons
        applyStimulus(B_SEL);
        applyStimulus(B_INC);
        checkOutput("clock_ignore_sel", 32'(field_sel), 32'd0);

        // btn_mode with tick: tick dropped, bank cleared entering STOPWATCH
        expectStrobe(3'b000, 3'b000, 8'd0, 1'b1, 1'b1);
        applyStimulus(B_MODE | B_TICK);
        checkOutput("sw_enter_rezhim", 32'(rezhim), 32'd1);
        checkOutput("sw_enter_cleared", 32'({bank_hr, bank_min, bank_sec}), 32'd0);

        // STOPWATCH: run, 3 ticks, inc ignored while running, stop, inc clears
        applyStimulus(B_START);
        for (int i = 0; i < 3; i++) begin
            expectStrobe(3'b001, 3'b000, 8'd0, 1'b0, 1'b1);
            applyStimulus(B_TICK);
        end
        applyStimulus(B_INC);
        checkOutput("sw_count", 32'(bank_sec), 32'd3);
        applyStimulus(B_START);
        expectStrobe(3'b000, 3'b000, 8'd0, 1'b1, 1'b1);
        applyStimulus(B_INC);
        checkOutput("sw_cleared", 32'(bank_sec), 32'd0);

        // TIMER: start at all-zero is ignored
        expectStrobe(3'b000, 3'b000, 8'd0, 1'b1, 1'b0);
        applyStimulus(B_MODE);
        checkOutput("tmr_rezhim", 32'(rezhim), 32'd2);
        checkOutput("tmr_up_down", 32'(up_down), 32'd0);
        applyStimulus(B_START);
        applyStimulus(B_TICK);
        checkOutput("tmr_zero_no_alarm", 32'(alarm), 32'd0);

        // TIMER: edit to 00:00:02 while idle, then count down to expiry
        expectStrobe(3'b000, 3'b001, 8'd1, 1'b0, 1'b0);
        applyStimulus(B_INC);
        expectStrobe(3'b000, 3'b001, 8'd2, 1'b0, 1'b0);
        applyStimulus(B_INC);
        checkOutput("tmr_loaded", 32'(bank_sec), 32'd2);
        applyStimulus(B_START);
        expectStrobe(3'b001, 3'b000, 8'd0, 1'b0, 1'b0);
        applyStimulus(B_TICK);
        expectStrobe(3'b001, 3'b000, 8'd0, 1'b0, 1'b0);
        applyStimulus(B_TICK);
        applyStimulus(B_TICK);
        checkOutput("tmr_alarm_set", 32'(alarm), 32'd1);
        repeat (9) applyStimulus(B_TICK);
        checkOutput("tmr_alarm_hold9", 32'(alarm), 32'd1);
        applyStimulus(B_TICK);
        checkOutput("tmr_alarm_clear10", 32'(alarm), 32'd0);

        // SET: hours wrap from 23, seconds 5 -> 6
        applyStimulus(B_MODE);
        checkOutput("set_rezhim", 32'(rezhim), 32'd3);
        checkOutput("set_up_down", 32'(up_down), 32'd1);
        applyStimulus(B_SEL);
        applyStimulus(B_SEL);
        checkOutput("set_field_hr", 32'(field_sel), 32'd2);
        presetBank(5'd23, 6'd0, 6'd0);
        expectStrobe(3'b000, 3'b100, 8'd0, 1'b0, 1'b1);
        applyStimulus(B_INC);
        checkOutput("set_hr_wrap", 32'(bank_hr), 32'd0);
        applyStimulus(B_SEL);
        checkOutput("set_field_wrap", 32'(field_sel), 32'd0);
        presetBank(5'd0, 6'd0, 6'd5);
        expectStrobe(3'b000, 3'b001, 8'd6, 1'b0, 1'b1);
        applyStimulus(B_INC);
        checkOutput("set_sec_inc", 32'(bank_sec), 32'd6);

        // Back round to a running TIMER, then reset mid-run
        applyStimulus(B_MODE);
        checkOutput("back_to_clock", 32'(rezhim), 32'd0);
        expectStrobe(3'b000, 3'b000, 8'd0, 1'b1, 1'b1);
        applyStimulus(B_MODE);
        expectStrobe(3'b000, 3'b000, 8'd0, 1'b1, 1'b0);
        applyStimulus(B_MODE);
        expectStrobe(3'b000, 3'b001, 8'd1, 1'b0, 1'b0);
        applyStimulus(B_INC);
        applyStimulus(B_START);
        tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
        checkOutput("pre_reset_sec_en", 32'(sec_en), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_rezhim", 32'(rezhim), 32'd0);
        checkOutput("midreset_alarm", 32'(alarm), 32'd0);
        checkOutput("midreset_strobes", 32'({sec_en, min_en, hr_en, timer_reset, setup_imp}), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(4);
        checkOutput("post_reset_up_down", 32'(up_down), 32'd1);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Mode and sequencing controller for the shared time-keeping counter bank: seconds (0..59), minutes (0..59) and hours (0..23) counters.
- Consumes a 1 Hz strobe, the counters' carry pulses and debounced button pulses.
- Drives each counter's work_en, up_down, setup_imp/setup_data and timer_reset, and runs the counter bank as a clock, stopwatch, countdown timer or setting interface.
- One counter bank is shared by all modes. Entering STOPWATCH or TIMER clears it.

Parameters:
- SEC_MAX, 59, seconds terminal value
- MIN_MAX, 59, minutes terminal value
- HR_MAX, 23, hours terminal value
- ALARM_TICKS, 10, number of tick strobes alarm stays high after timer expiry

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle 1 Hz strobe from prescaler counter
- btn_mode  in  1  one-cycle pulse, advance mode
- btn_sel  in  1  one-cycle pulse, advance selected field
- btn_inc  in  1  one-cycle pulse, increment field / clear stopwatch
- btn_start  in  1  one-cycle pulse, start/stop
- sec_val  in  6  seconds counter value
- min_val  in  6  minutes counter value
- hr_val  in  5  hours counter value
- sec_imp  in  1  seconds counter out_imp (carry/borrow)
- min_imp  in  1  minutes counter out_imp
- rezhim  out  2  mode: 0 CLOCK, 1 STOPWATCH, 2 TIMER, 3 SET
- sec_en  out  1  seconds work_en
- min_en  out  1  minutes work_en
- hr_en  out  1  hours work_en
- up_down  out  1  1 count up, 0 count down (common to all counters)
- setup_imp  out  3  one-hot load strobe: [0] sec, [1] min, [2] hr
- setup_data  out  8  load value, zero-extended
- timer_reset  out  1  clear all counters to start_val
- field_sel  out  2  selected field for display blink: 0 sec, 1 min, 2 hr
- alarm  out  1  timer expiry indication

Behaviour:
- Reset values: all outputs registered. Reset gives rezhim=0 (CLOCK), run=0, field_sel=0, alarm=0, all strobes/enables=0, setup_data=0, up_down=1.
- Latency: every output changes the cycle after the causing input. Strobes (sec_en, min_en, hr_en, setup_imp, timer_reset) are exactly one cycle wide.
- Priority within a cycle: btn_mode > btn_start > btn_sel > btn_inc > tick. A tick coinciding with btn_mode is dropped. A tick coinciding with a lower-priority button is still processed using the pre-button state.
- Mode FSM: btn_mode cycles CLOCK→STOPWATCH→TIMER→SET→CLOCK.
  - Entering STOPWATCH or TIMER: pulse timer_reset, set run=0.
  - Entering SET: field_sel=0.
  - Any mode change clears alarm.
- Carry chain, all modes with run=1:
  - sec_en = tick.
  - min_en = sec_imp.
  - hr_en = min_imp.
  - The counters wrap on their own at SEC_MAX/MIN_MAX/HR_MAX (up) or at 0 (down).
- CLOCK: run forced 1, up_down=1. Buttons other than btn_mode are ignored.
- STOPWATCH: up_down=1.
  - btn_start toggles run.
  - btn_inc with run=0 pulses timer_reset. btn_inc with run=1 is ignored.
- TIMER sub-FSM (T_IDLE, T_RUN, T_DONE), up_down=0.
  - T_IDLE: btn_sel and btn_inc edit fields exactly as in SET. btn_start goes to T_RUN only if the counters are not all zero; otherwise it is ignored.
  - T_RUN: btn_start returns to T_IDLE. On tick with sec_val=min_val=hr_val=0, no sec_en is issued; go to T_DONE, alarm=1, load alarm counter with ALARM_TICKS.
  - T_DONE: alarm counter decrements per tick. Reaching 0, or any button except btn_mode, sets alarm=0 and goes to T_IDLE.
- SET: run=0, up_down=1.
  - btn_sel: field_sel 0→1→2→0.
  - btn_inc: setup_imp one-hot for field_sel. setup_data = selected value + 1, or 0 if value equals its MAX.
- Mid-operation reset: returns everything to reset values immediately. Asynchronous assertion, synchronous release.

Decomposition:
- Package clock_pkg holds:
  - enum mode_t {CLOCK, STOPWATCH, TIMER, SET}
  - enum tmr_state_t {T_IDLE, T_RUN, T_DONE}
  - field index constants
  - width constants 6/6/5
- One sub-module, field_inc: combinational next-value with wrap for the selected field. It is shared by SET and T_IDLE.

Test Plan:
- CLOCK, counters at 00:59:59, one tick → sec_en high cycle+1; min_en follows sec_imp; hr_en follows min_imp; bank reads 01:00:00.
- SET, field_sel=2, hr_val=23, btn_inc → setup_imp=3'b100, setup_data=8'd0; field_sel=0, sec_val=5, btn_inc → setup_imp=3'b001, setup_data=8'd6.
- TIMER, set 00:00:02, btn_start, 3 ticks → two sec_en pulses with up_down=0; third tick gives no sec_en, alarm=1; alarm=0 after 10 further ticks.
- TIMER at 00:00:00, btn_start → state stays T_IDLE, no sec_en on subsequent ticks.
- STOPWATCH: btn_start, 3 ticks, btn_start, btn_inc → 3 sec_en pulses then timer_reset pulse; btn_inc while running → no timer_reset.
- btn_mode and tick in same cycle while in CLOCK → rezhim=1, timer_reset pulse, no sec_en; reset asserted during T_RUN → rezhim=0, alarm=0, all strobes 0 in the same cycle.
